// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot and binary grant outputs; grants are held until done.
// Optional hold-time limit with forced release is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_onehot_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt, arb_ptr, winner;
    logic             valid_nxt, release_now, expire, new_grant;

    if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
        $error("rr_onehot_arbiter: N and MAX_HOLD must both be >= 2");
    end

    // Circular first-set scan of r starting at position p.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] w, pos;
        logic             found;
        int               j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) j = j - N;
            pos = IDX_W'(j);
            if (!found && r[pos]) begin
                w     = pos;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [N-1:0] decode(input logic [IDX_W-1:0] i);
        logic [N-1:0] one;
        one    = '0;
        one[i] = 1'b1;
        return one;
    endfunction

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;

    // hold_cnt is 0 in the first BUSY cycle, so MAX_HOLD-1 marks the last allowed cycle.
    assign expire = (state == BUSY) && !done && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (new_grant)
                hold_cnt <= '0;
            else if (state == BUSY)
                hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign release_now = (state == BUSY) && (done || expire);
    // A release re-arbitrates from the slot after the outgoing owner on the same edge.
    assign arb_ptr     = release_now ? wrap_inc(grant_idx) : ptr;
    assign winner      = pick(req, arb_ptr);
    assign new_grant   = (state_nxt == BUSY) && ((state == IDLE) || release_now);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        valid_nxt = grant_valid;
        idx_nxt   = grant_idx;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = BUSY;
                    valid_nxt = 1'b1;
                    idx_nxt   = winner;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nxt = arb_ptr;
                    if (|req) begin
                        idx_nxt = winner;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        idx_nxt   = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            grant       <= valid_nxt ? decode(idx_nxt) : '0;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboarded bench for rr_onehot_arbiter: directed scenarios then random traffic against a rule-level model.
// Define RR_ARB_TIMEOUT_EN for both bench and RTL to exercise the forced-release path.
module tb_rr_onehot_arbiter;

    localparam int N        = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    rr_onehot_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        bit valid;
        int idx;
        bit to;
    } exp_t;

    exp_t exp_q[$];
    bit   sb_en = 1'b0;

    // Reference model: owner, pointer and cycles-held, advanced once per rising edge.
    bit m_busy;
    int m_idx, m_ptr, m_held;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
        m_held = 0;
    endtask

    task automatic model_step();
        bit   rel, to;
        exp_t e;
        to = 1'b0;
        if (m_busy) begin
            m_held++;
            rel = done;
            if (!done && TO_EN && m_held == MAX_HOLD) begin
                rel = 1'b1;
                to  = 1'b1;
            end
            if (rel) begin
                m_ptr = (m_idx + 1) % N;
                if (req != 0) begin
                    m_idx  = pick(req, m_ptr);
                    m_held = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (req != 0) begin
            m_idx  = pick(req, m_ptr);
            m_busy = 1'b1;
            m_held = 0;
        end
        e.valid = m_busy;
        e.idx   = m_idx;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (sb_en && reset_n) model_step();
    end

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_en) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("sb_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_valid", grant_valid, e.valid);
                check("sb_grant", grant, e.valid ? (32'd1 << e.idx) : 32'd0);
                if (e.valid) check("sb_idx", grant_idx, e.idx);
                check("sb_timeout", timeout, e.to);
            end
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic d, input logic ev, input int ei, input logic et);
        @(negedge clk);
        #1;
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        check("dir_valid", grant_valid, ev);
        if (ei >= 0) check("dir_idx", grant_idx, ei);
        check("dir_timeout", timeout, et);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", grant_valid, 0);
        check("rst_grant", grant, 0);
        check("rst_idx", grant_idx, 0);
        check("rst_timeout", timeout, 0);

        @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        check("first_idx", grant_idx, 0);
        check("first_grant", grant, 4'b0001);

        cyc(4'b0000, 1'b1, 1'b0, -1, 1'b0);
        // Single request; owner drops req and others appear, grant must hold.
        cyc(4'b0100, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1011, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, -1, 1'b0);
        // Wrap and skip from ptr = 3.
        cyc(4'b0011, 1'b0, 1'b1, 0, 1'b0);
        cyc(4'b0011, 1'b1, 1'b1, 1, 1'b0);
        cyc(4'b0001, 1'b1, 1'b1, 0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, -1, 1'b0);
        // All requesting: back-to-back rotation from ptr = 1.
        cyc(4'b1111, 1'b0, 1'b1, 1, 1'b0);
        for (int g = 1; g <= 5; g++) begin
            cyc(4'b1111, 1'b0, 1'b1, g % N, 1'b0);
            cyc(4'b1111, 1'b1, 1'b1, (1 + g) % N, 1'b0);
        end
        cyc(4'b0000, 1'b1, 1'b0, -1, 1'b0);
        // Hold limit: idx 0 held MAX_HOLD cycles, then forced over to idx 1 when enabled.
        cyc(4'b0011, 1'b0, 1'b1, 0, 1'b0);
        repeat (MAX_HOLD - 1) cyc(4'b0011, 1'b0, 1'b1, 0, 1'b0);
        cyc(4'b0011, 1'b0, 1'b1, TO_EN ? 1 : 0, TO_EN);
        cyc(4'b0011, 1'b0, 1'b1, TO_EN ? 1 : 0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, -1, 1'b0);

        // Asynchronous reset mid-grant, then ptr must restart from 0.
        cyc(4'b1000, 1'b0, 1'b1, 3, 1'b0);
        sb_en = 1'b0;
        exp_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", grant_valid, 0);
        check("async_grant", grant, 0);
        req = 4'b0101;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        check("ptr_reset_idx", grant_idx, 0);

        repeat (3000) begin
            @(negedge clk);
            #1;
            req  = N'($urandom);
            if ($urandom_range(0, 7) == 0) req = '0;
            done = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        #1;
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
